// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared constants for mult_pipe_hs (pipeline depth, widest product) and the Baugh-Wooley correction-constant helper
package mult_pipe_pkg;
  localparam int STAGES = 3;
  localparam int MAX_PW = 64;
  function automatic logic [MAX_PW-1:0] bw_corr(input int w);
    return (MAX_PW'(1) << w) | (MAX_PW'(1) << (2 * w - 1));
  endfunction
endpackage

// File: rtl/mult_pipe_hs_if.sv
// mult_pipe_hs_if: operand/result handshake bundle; master = producer+consumer side, slave = multiplier side (in_valid/x/y/signed/tag, out_ready in; in_ready, out_valid/prod/tag out)
interface mult_pipe_hs_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_x;
  logic [WIDTH-1:0]   in_y;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]   out_tag;
  modport master (
    output in_valid, in_x, in_y, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag
  );
  modport slave (
    input  in_valid, in_x, in_y, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag
  );
endinterface

// File: rtl/mult_pipe_hs_prefix_adder.sv
// prefix_adder_w: N-bit Sklansky parallel-prefix adder (a, b in; sum out, carry-in 0, carry-out dropped) built from GREY/BLACK cells
module prefix_adder_w #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum
);
  localparam int L = $clog2(N);
  always_comb begin
    logic [N-1:0] h, g, p, g_n, p_n;
    int j;
    h = a ^ b;
    g = a & b;
    p = h;
    for (int l = 0; l < L; l++) begin
      g_n = g;
      p_n = p;
      for (int i = 0; i < N; i++) begin
        if (((i >> l) & 1) == 1) begin
          j = ((i >> l) << l) - 1;
          g_n[i] = g[i] | (p[i] & g[j]);
          p_n[i] = (i < (2 << l)) ? p[i] : p[i] & p[j];
        end
      end
      g = g_n;
      p = p_n;
    end
    sum = h ^ {g[N-2:0], 1'b0};
  end
endmodule

// File: rtl/mult_pipe_hs.sv
// mult_pipe_hs: 3-stage signed/unsigned multiplier (S1 partial products, S2 carry-save, S3 prefix add) with tag passthrough; clk, rst, bus (mult_pipe_hs_if.slave)
module mult_pipe_hs
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst,
  mult_pipe_hs_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] CORR = PW'(bw_corr(WIDTH));
  typedef struct packed {
    logic [WIDTH-1:0][WIDTH-1:0] pp;
    logic                        sgn;
    logic [TAG_W-1:0]            tag;
  } s1_t;
  typedef struct packed {
    logic [PW-1:0]    row_a;
    logic [PW-1:0]    row_b;
    logic [TAG_W-1:0] tag;
  } s2_t;
  logic v1, v2, v3, adv1, adv2, adv3;
  s1_t s1, s1_n;
  s2_t s2, s2_n;
  logic [PW-1:0] sum;
  assign adv3 = !v3 || bus.out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = v3;
  always_comb begin
    s1_n = '0;
    s1_n.sgn = bus.in_signed;
    s1_n.tag = bus.in_tag;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        s1_n.pp[i][j] = (bus.in_x[j] & bus.in_y[i]) ^ (bus.in_signed && ((i == WIDTH - 1) != (j == WIDTH - 1)));
  end
  always_comb begin
    logic [PW-1:0] s, c, r, t;
    s = PW'(s1.pp[0]);
    c = PW'(s1.pp[1]) << 1;
    for (int k = 2; k < WIDTH; k++) begin
      r = PW'(s1.pp[k]) << k;
      t = s ^ c ^ r;
      c = ((s & c) | (s & r) | (c & r)) << 1;
      s = t;
    end
    r = s1.sgn ? CORR : '0;
    t = s ^ c ^ r;
    c = ((s & c) | (s & r) | (c & r)) << 1;
    s2_n = '{row_a: t, row_b: c, tag: s1.tag};
  end
  prefix_adder_w #(.N(PW)) u_add (
    .a  (s2.row_a),
    .b  (s2.row_b),
    .sum(sum)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      bus.out_prod <= '0;
      bus.out_tag <= '0;
    end else begin
      if (adv1) v1 <= bus.in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
      if (adv3 && v2) begin
        bus.out_prod <= sum;
        bus.out_tag <= s2.tag;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (adv1 && bus.in_valid) s1 <= s1_n;
    if (adv2 && v1) s2 <= s2_n;
  end
endmodule
